// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the LED pulse stretcher.
package pulse_stretcher_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      GAP  = 2'b10
   } statetype;

   function automatic int cnt_width(input int hold, input int gap);
      int m;
      int w;
      m = (hold > gap) ? hold : gap;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pulse_stretcher_load_down_counter.sv
// Loadable down-counter; load wins over decrement, zero flags cnt == 0.
module load_down_counter #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches 1-cycle strobes into HOLD_CYCLES LED levels separated by
// GAP_CYCLES off-time, queueing strobes that arrive while busy.
module pulse_stretcher
   import pulse_stretcher_pkg::*;
#(
   parameter int HOLD_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int PEND_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   output logic              level_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   statetype          state_q, state_d;
   logic              pulse_in_d_q, pulse_in_d_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;

   logic              ev;
   logic              cnt_load;
   logic [CW-1:0]     cnt_value;
   logic              cnt_dec;
   logic              cnt_zero;

   assign ev = pulse_in & ~pulse_in_d_q;

   load_down_counter #(.W(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .value (cnt_value),
      .dec   (cnt_dec),
      .zero  (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      pulse_in_d_d = pulse_in;
      pending_d    = pending_q;
      overflow_d   = overflow_q;
      cnt_load     = 1'b0;
      cnt_value    = HOLD_LD;
      cnt_dec      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ev) begin
               state_d  = HOLD;
               cnt_load = 1'b1;
            end
         end
         HOLD: begin
            if (ev) begin
               if (pending_q == PEND_MAX) overflow_d = 1'b1;
               else pending_d = pending_q + 1'b1;
            end
            if (cnt_zero) begin
               state_d   = GAP;
               cnt_load  = 1'b1;
               cnt_value = GAP_LD;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         GAP: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
               if (ev) begin
                  if (pending_q == PEND_MAX) overflow_d = 1'b1;
                  else pending_d = pending_q + 1'b1;
               end
            end else if (pending_q != '0) begin
               // a simultaneous new event replaces the one being dequeued
               state_d  = HOLD;
               cnt_load = 1'b1;
               if (!ev) pending_d = pending_q - 1'b1;
            end else if (ev) begin
               state_d  = HOLD;
               cnt_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pulse_in_d_q <= 1'b0;
         pending_q    <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pulse_in_d_q <= pulse_in_d_d;
         pending_q    <= pending_d;
         overflow_q   <= overflow_d;
      end
   end

   assign level_out = state_q[0];
   assign busy      = (state_q != IDLE);
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher with HOLD=4, GAP=2, PEND_W=2.
module tb_pulse_stretcher;

   localparam int HOLD = 4;
   localparam int GAP  = 2;
   localparam int PW   = 2;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pulse_in = 1'b0;
   logic          level_out;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   int n_chk  = 0;
   int n_pass = 0;

   pulse_stretcher #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .PEND_W      (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pulse_in  (pulse_in),
      .level_out (level_out),
      .busy      (busy),
      .pending   (pending),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       p;
      logic       lv;
      logic       bz;
      logic [1:0] pd;
      logic       ov;
   } vec_t;

   vec_t tab[32];

   task automatic check(input string name, input int c, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, exp);
   endtask

   task automatic check_all(input string tag, input int c, input logic lv, input logic bz,
                            input int pd, input logic ov);
      check({tag, ".level"}, c, int'(level_out), int'(lv));
      check({tag, ".busy"}, c, int'(busy), int'(bz));
      check({tag, ".pending"}, c, int'(pending), pd);
      check({tag, ".overflow"}, c, int'(overflow), int'(ov));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pulse_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Timeline reference: phase counts cycles since the current hold began.
   bit m_active;
   int m_ph;
   int m_pend;
   bit m_ovf;
   bit m_prev;

   task automatic model_reset();
      m_active = 0;
      m_ph = 0;
      m_pend = 0;
      m_ovf = 0;
      m_prev = 0;
   endtask

   task automatic model_edge(input bit p);
      bit ev;
      ev = p && !m_prev;
      m_prev = p;
      if (!m_active) begin
         if (ev) begin
            m_active = 1;
            m_ph = 0;
         end
      end else if (m_ph == HOLD + GAP - 1) begin
         if (m_pend > 0) begin
            m_ph = 0;
            m_pend = m_pend - 1 + (ev ? 1 : 0);
         end else if (ev) begin
            m_ph = 0;
         end else begin
            m_active = 0;
         end
      end else begin
         if (ev) begin
            if (m_pend == PMAX) m_ovf = 1;
            else m_pend++;
         end
         m_ph++;
      end
   endtask

   initial begin
      logic [63:0] pm;
      bit in_rng;

      // Strobes at 10, 12, 14: first hold 11-14, queued holds 17-20, 23-26.
      for (int c = 0; c < 32; c++) begin
         tab[c].p  = (c == 10 || c == 12 || c == 14);
         tab[c].lv = (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26);
         tab[c].bz = (c >= 11 && c <= 28);
         tab[c].ov = 1'b0;
         if (c >= 23) tab[c].pd = 2'd0;
         else if (c >= 17) tab[c].pd = 2'd1;
         else if (c >= 15) tab[c].pd = 2'd2;
         else if (c >= 13) tab[c].pd = 2'd1;
         else tab[c].pd = 2'd0;
      end

      do_reset();
      for (int c = 0; c < 32; c++) begin
         check_all("tab", c, tab[c].lv, tab[c].bz, int'(tab[c].pd), tab[c].ov);
         pulse_in = tab[c].p;
         @(negedge clk);
      end

      // Input held high 10-29 is a single event.
      do_reset();
      for (int c = 0; c < 36; c++) begin
         check("held.level", c, int'(level_out), (c >= 11 && c <= 14) ? 1 : 0);
         check("held.pending", c, int'(pending), 0);
         if (c >= 17) check("held.busy", c, int'(busy), 0);
         pulse_in = (c >= 10 && c <= 29);
         @(negedge clk);
      end

      // Saturation: strobes 10..20 every other cycle; overflow is sticky.
      do_reset();
      pm = '0;
      for (int i = 10; i <= 20; i += 2) pm[i] = 1'b1;
      for (int c = 0; c < 52; c++) begin
         if (c == 19) check("sat.pending19", c, int'(pending), 3);
         if (c == 20) check("sat.ovf20", c, int'(overflow), 0);
         if (c == 21) begin
            check("sat.pending21", c, int'(pending), 3);
            check("sat.ovf21", c, int'(overflow), 1);
         end
         if (c == 40) check("sat.busy40", c, int'(busy), 1);
         if (c == 41) check("sat.busy41", c, int'(busy), 0);
         if (c == 51) check_all("sat.idle", c, 1'b0, 1'b0, 0, 1'b1);
         pulse_in = pm[c];
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check("sat.ovf_rst", 0, int'(overflow), 0);
      @(negedge clk);

      // Strobe on the last gap cycle with nothing queued: no idle cycle.
      do_reset();
      for (int c = 0; c < 26; c++) begin
         in_rng = (c >= 11 && c <= 22);
         check("gap5.busy", c, int'(busy), int'(in_rng));
         check("gap5.level", c, int'(level_out),
               ((c >= 11 && c <= 14) || (c >= 17 && c <= 20)) ? 1 : 0);
         check("gap5.pending", c, int'(pending), 0);
         pulse_in = (c == 10 || c == 16);
         @(negedge clk);
      end

      // Async reset mid-hold with two queued, then a clean single strobe.
      do_reset();
      for (int c = 0; c < 18; c++) begin
         pulse_in = (c == 10 || c == 12 || c == 14 || c == 16);
         @(negedge clk);
      end
      check_all("prerst", 18, 1'b1, 1'b1, 2, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_all("asyncrst", 18, 1'b0, 1'b0, 0, 1'b0);
      pulse_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 22; c++) begin
         check("post.level", c, int'(level_out), (c >= 11 && c <= 14) ? 1 : 0);
         check("post.pending", c, int'(pending), 0);
         if (c >= 11 && c <= 16) check("post.busy_on", c, int'(busy), 1);
         if (c >= 17) check("post.busy_off", c, int'(busy), 0);
         pulse_in = (c == 10);
         @(negedge clk);
      end

      // Random strobes against the timeline reference.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         model_reset();
         for (int c = 0; c < 300; c++) begin
            bit p;
            check_all("rand", c, m_active && (m_ph < HOLD), m_active, m_pend, m_ovf);
            case (r)
               0: p = ($urandom_range(0, 3) == 0);
               1: p = ($urandom_range(0, 1) == 0);
               default: p = ($urandom_range(0, 9) == 0);
            endcase
            pulse_in = p;
            model_edge(p);
            @(negedge clk);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
